// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift left/right, rotate left/right and parallel load,
// with a bit counter that pulses frame_done one cycle after every WIDTH-th shift.
module shift_reg_univ #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           par_in,
  input  logic                       ser_in,
  output logic [WIDTH-1:0]           par_out,
  output logic                       ser_out,
  output logic                       dir,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt,
  output logic                       frame_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROTL = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             dir_next;
  logic             is_shift;
  logic             is_load;

  always_comb begin
    q_next   = q;
    dir_next = dir;
    is_shift = 1'b0;
    is_load  = 1'b0;
    unique case (mode)
      MODE_SHL: begin
        q_next   = {q[WIDTH-2:0], ser_in};
        dir_next = 1'b0;
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        q_next   = {ser_in, q[WIDTH-1:1]};
        dir_next = 1'b1;
        is_shift = 1'b1;
      end
      MODE_ROTL: begin
        q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
        dir_next = 1'b0;
        is_shift = 1'b1;
      end
      MODE_ROTR: begin
        q_next   = {q[0], q[WIDTH-1:1]};
        dir_next = 1'b1;
        is_shift = 1'b1;
      end
      MODE_LOAD: begin
        q_next  = par_in;
        is_load = 1'b1;
      end
      MODE_HOLD: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= RESET_VAL;
      dir        <= 1'b0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (en) begin
      q   <= q_next;
      dir <= dir_next;
      // Any shift kind advances the frame; a load restarts it.
      if (is_load) begin
        bit_cnt    <= '0;
        frame_done <= 1'b0;
      end else if (is_shift) begin
        if (bit_cnt == CNT_LAST) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt    <= bit_cnt + 1'b1;
          frame_done <= 1'b0;
        end
      end else begin
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

  assign par_out = q;
  // The bit the next shift in the current direction will push out.
  assign ser_out = dir ? q[0] : q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: 8-bit and 16-bit instances driven in lockstep
// and compared against an arithmetic reference model.
module tb_shift_reg_univ;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic [7:0]  par8 = '0;
  logic [15:0] par16 = '0;
  logic        ser = 1'b0;

  logic [7:0]  q8;
  logic        so8, dir8, fd8;
  logic [2:0]  cnt8;
  logic [15:0] q16;
  logic        so16, dir16, fd16;
  logic [3:0]  cnt16;

  int errors = 0;
  int checks = 0;

  int m8_q, m8_d, m8_c, m8_f;
  int m16_q, m16_d, m16_c, m16_f;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .par_in(par8), .ser_in(ser),
    .par_out(q8), .ser_out(so8), .dir(dir8), .bit_cnt(cnt8), .frame_done(fd8)
  );

  shift_reg_univ #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .par_in(par16), .ser_in(ser),
    .par_out(q16), .ser_out(so16), .dir(dir16), .bit_cnt(cnt16), .frame_done(fd16)
  );

  // Reference: register value as an integer, shifts as multiply/divide/modulo.
  task automatic mstep(input int w, input logic e, input logic [2:0] md, input int p,
                       input logic s, inout int q, inout int d, inout int c, inout int f);
    int full, msb, sv;
    bit shifted;
    full = 1 << w;
    msb  = 1 << (w - 1);
    sv   = s ? 1 : 0;
    shifted = 0;
    f = 0;
    if (e) begin
      case (md)
        3'd1: begin q = (q * 2 + sv) % full;            d = 0; shifted = 1; end
        3'd2: begin q = q / 2 + sv * msb;               d = 1; shifted = 1; end
        3'd3: begin q = (q * 2) % full + q / msb;       d = 0; shifted = 1; end
        3'd4: begin q = q / 2 + (q % 2) * msb;          d = 1; shifted = 1; end
        3'd5: begin q = p; c = 0; end
        default: ;
      endcase
      if (shifted) begin
        c = (c + 1) % w;
        f = (c == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic model_reset();
    m8_q = 0; m8_d = 0; m8_c = 0; m8_f = 0;
    m16_q = 0; m16_d = 0; m16_c = 0; m16_f = 0;
  endtask

  // Called at a falling edge; applies inputs, advances the model, waits for the next falling edge.
  task automatic tick(input logic e, input logic [2:0] md, input logic [15:0] p, input logic s);
    en = e; mode = md; par8 = p[7:0]; par16 = p; ser = s;
    mstep(8,  e, md, int'(p[7:0]), s, m8_q,  m8_d,  m8_c,  m8_f);
    mstep(16, e, md, int'(p),      s, m16_q, m16_d, m16_c, m16_f);
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (q8 !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", q8); end
    checks++; if (cnt8 !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt8); end
    checks++; if (fd8 !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", fd8); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick(1, 3'd5, 16'h12A5, 0);
    for (int i = 0; i < 4; i++) tick(1, 3'd1, 16'h0, 1);
    tick(1, 3'd2, 16'h0, 0);
    checks++; if (cnt8 !== 3'd5 || dir8 !== 1'b1) begin
      errors++; $display("FAIL pre_reset_state cnt=%0d dir=%b exp cnt=5 dir=1", cnt8, dir8);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (q8 !== 8'h00 || q16 !== 16'h0000) begin
      errors++; $display("FAIL async_reset_q got=%h/%h exp=00/0000", q8, q16);
    end
    checks++; if (cnt8 !== 3'd0 || cnt16 !== 4'd0) begin
      errors++; $display("FAIL async_reset_cnt got=%0d/%0d exp=0/0", cnt8, cnt16);
    end
    checks++; if (dir8 !== 1'b0 || fd8 !== 1'b0) begin
      errors++; $display("FAIL async_reset_dir_fd got dir=%b fd=%b exp 0 0", dir8, fd8);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_shl_frame();
    logic [7:0] pat;
    pat = 8'hA5;
    tick(1, 3'd5, 16'h00A5, 0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (so8 !== pat[7-i]) begin
        errors++; $display("FAIL shl_ser_out[%0d] got=%b exp=%b", i, so8, pat[7-i]);
      end
      tick(1, 3'd1, 16'h0, 0);
    end
    checks++; if (q8 !== 8'h00 || cnt8 !== 3'd0) begin
      errors++; $display("FAIL shl_frame_end q=%h cnt=%0d exp q=00 cnt=0", q8, cnt8);
    end
    checks++; if (fd8 !== 1'b1) begin errors++; $display("FAIL shl_frame_done got=%b exp=1", fd8); end
    checks++; if (q16 !== 16'(m16_q) || fd16 !== 1'b0) begin
      errors++; $display("FAIL shl_w16 q=%h fd=%b exp q=%h fd=0", q16, fd16, 16'(m16_q));
    end
    tick(1, 3'd0, 16'h0, 0);
    checks++; if (fd8 !== 1'b0) begin errors++; $display("FAIL shl_frame_done_len got=%b exp=0", fd8); end
  endtask

  task automatic test_shr();
    tick(1, 3'd5, 16'h0001, 0);
    for (int i = 0; i < 3; i++) tick(1, 3'd2, 16'h0, 1);
    checks++; if (q8 !== 8'hE0 || dir8 !== 1'b1) begin
      errors++; $display("FAIL shr_q_dir q=%h dir=%b exp q=e0 dir=1", q8, dir8);
    end
    checks++; if (so8 !== 1'b0 || cnt8 !== 3'd3) begin
      errors++; $display("FAIL shr_so_cnt so=%b cnt=%0d exp so=0 cnt=3", so8, cnt8);
    end
  endtask

  task automatic test_rotate();
    tick(1, 3'd5, 16'h0081, 1);
    tick(1, 3'd3, 16'h0, 0);
    checks++; if (q8 !== 8'h03) begin errors++; $display("FAIL rotl got=%h exp=03", q8); end
    tick(1, 3'd4, 16'h0, 0);
    tick(1, 3'd4, 16'h0, 1);
    checks++; if (q8 !== 8'hC0 || cnt8 !== 3'd3 || fd8 !== 1'b0) begin
      errors++; $display("FAIL rotr q=%h cnt=%0d fd=%b exp q=c0 cnt=3 fd=0", q8, cnt8, fd8);
    end
  endtask

  task automatic test_enable();
    tick(1, 3'd5, 16'h003C, 0);
    for (int i = 0; i < 3; i++) tick(1, 3'd1, 16'h0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(0, 3'd1, 16'h0, 1);
      checks++; if (q8 !== 8'hE7 || cnt8 !== 3'd3 || dir8 !== 1'b0) begin
        errors++; $display("FAIL en_low_hold[%0d] q=%h cnt=%0d dir=%b exp q=e7 cnt=3 dir=0", i, q8, cnt8, dir8);
      end
    end
    for (int i = 0; i < 4; i++) tick(1, 3'd1, 16'h0, 0);
    checks++; if (cnt8 !== 3'd7) begin errors++; $display("FAIL cnt_before_load got=%0d exp=7", cnt8); end
    tick(1, 3'd5, 16'h0055, 0);
    checks++; if (q8 !== 8'h55 || cnt8 !== 3'd0 || fd8 !== 1'b0) begin
      errors++; $display("FAIL load_at_7 q=%h cnt=%0d fd=%b exp q=55 cnt=0 fd=0", q8, cnt8, fd8);
    end
    tick(1, 3'd0, 16'h0, 0);
    checks++; if (fd8 !== 1'b0) begin errors++; $display("FAIL load_no_pulse got=%b exp=0", fd8); end
  endtask

  task automatic test_hold();
    logic [2:0] hm [3];
    hm[0] = 3'b111; hm[1] = 3'b000; hm[2] = 3'b110;
    tick(1, 3'd5, 16'h5A5A, 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        tick(1, hm[k], 16'hFFFF, i[0]);
        checks++; if (q8 !== 8'h5A || q16 !== 16'h5A5A || cnt8 !== 3'd0) begin
          errors++; $display("FAIL hold_mode%0d[%0d] q=%h/%h cnt=%0d exp 5a/5a5a 0", hm[k], i, q8, q16, cnt8);
        end
      end
    end
  endtask

  task automatic test_width16();
    int pulses, at;
    pulses = 0; at = -1;
    tick(1, 3'd5, 16'hBEEF, 0);
    for (int i = 0; i < 16; i++) begin
      tick(1, 3'd1, 16'h0, 1'($urandom_range(0, 1)));
      if (fd16 === 1'b1) begin pulses++; at = i; end
    end
    checks++; if (q16 !== 16'(m16_q)) begin
      errors++; $display("FAIL w16_q got=%h exp=%h", q16, 16'(m16_q));
    end
    tick(1, 3'd0, 16'h0, 0);
    if (fd16 === 1'b1) pulses++;
    checks++; if (pulses != 1 || at != 15) begin
      errors++; $display("FAIL w16_frame_done pulses=%0d at=%0d exp pulses=1 at=15", pulses, at);
    end
  endtask

  task automatic test_random();
    logic [2:0] md;
    logic e;
    int exp_so8, exp_so16;
    for (int n = 0; n < 600; n++) begin
      e  = ($urandom_range(0, 7) != 0);
      md = ($urandom_range(0, 15) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
      tick(e, md, 16'($urandom), 1'($urandom_range(0, 1)));
      exp_so8  = m8_d  ? m8_q % 2  : m8_q / 128;
      exp_so16 = m16_d ? m16_q % 2 : m16_q / 32768;
      checks++; if (q8 !== 8'(m8_q) || dir8 !== 1'(m8_d) || cnt8 !== 3'(m8_c) || fd8 !== 1'(m8_f)) begin
        errors++; $display("FAIL rand8[%0d] q=%h dir=%b cnt=%0d fd=%b exp q=%h dir=%0d cnt=%0d fd=%0d",
                           n, q8, dir8, cnt8, fd8, 8'(m8_q), m8_d, m8_c, m8_f);
      end
      checks++; if (so8 !== 1'(exp_so8)) begin
        errors++; $display("FAIL rand8_ser_out[%0d] got=%b exp=%0d", n, so8, exp_so8);
      end
      checks++; if (q16 !== 16'(m16_q) || dir16 !== 1'(m16_d) || cnt16 !== 4'(m16_c) || fd16 !== 1'(m16_f)) begin
        errors++; $display("FAIL rand16[%0d] q=%h dir=%b cnt=%0d fd=%b exp q=%h dir=%0d cnt=%0d fd=%0d",
                           n, q16, dir16, cnt16, fd16, 16'(m16_q), m16_d, m16_c, m16_f);
      end
      checks++; if (so16 !== 1'(exp_so16)) begin
        errors++; $display("FAIL rand16_ser_out[%0d] got=%b exp=%0d", n, so16, exp_so16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shl_frame();
    test_shr();
    test_rotate();
    test_enable();
    test_hold();
    test_width16();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
